// File: rtl/av_st_pkg.sv
// Shared types for the Avalon-ST channel demultiplexer: the beat record
// for the default configuration and the packet-routing state.
package av_st_pkg;

    localparam int BITS_PER_SYMBOL  = 8;
    localparam int SYMBOLS_PER_BEAT = 4;
    localparam int CHAN_WIDTH       = 1;
    localparam int DATA_WIDTH       = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int EMPTY_WIDTH      = $clog2(SYMBOLS_PER_BEAT);

    typedef struct packed {
        logic [CHAN_WIDTH-1:0]  channel;
        logic [DATA_WIDTH-1:0]  data;
        logic [EMPTY_WIDTH-1:0] empty;
        logic                   sop;
        logic                   eop;
        logic                   error;
    } beat_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } route_state_t;

endpackage

// File: rtl/av_st_chan_demux_if.sv
// One Avalon-ST stream. valid/ready: a beat transfers on a clock edge where
// both are high; the source holds the beat stable while valid && !ready.
interface av_st_chan_demux_if #(
    parameter int CHAN_WIDTH  = 1,
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2
) ();

    logic [CHAN_WIDTH-1:0]  channel;
    logic [DATA_WIDTH-1:0]  data;
    logic [EMPTY_WIDTH-1:0] empty;
    logic                   startofpacket;
    logic                   endofpacket;
    logic                   error;
    logic                   valid;
    logic                   ready;

    modport master (
        output channel, data, empty, startofpacket, endofpacket, error, valid,
        input  ready
    );

    modport slave (
        input  channel, data, empty, startofpacket, endofpacket, error, valid,
        output ready
    );

endinterface

// File: rtl/av_st_skid_fifo2.sv
// Two-entry FIFO whose not-full flag is registered from next-state occupancy,
// so the writer's ready never depends combinationally on the reader.
module av_st_skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_not_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_not_full;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_next;

    assign w_push       = i_wr_en && r_not_full;
    assign w_pop        = i_rd_en && (r_count != 2'd0);
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_not_full <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count    <= w_count_next;
            r_not_full <= (w_count_next < 2'd2);
        end
    end

    // Payload storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_not_full = r_not_full;
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_rd_valid = (r_count != 2'd0);

endmodule

// File: rtl/av_st_chan_demux.sv
// Packet-aware 1-to-2 Avalon-ST demux: whole packets are steered to out0 or
// out1 by the channel seen on their startofpacket beat.
module av_st_chan_demux
    import av_st_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 4,
    parameter int CHAN_WIDTH       = 1,
    parameter int PORT1_CHANNEL    = 1,
    parameter int DROP_CNT_WIDTH   = 16,
    localparam int DATA_WIDTH      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
    localparam int EMPTY_WIDTH     = $clog2(SYMBOLS_PER_BEAT)
) (
    input  logic                      clk,
    input  logic                      reset,
    av_st_chan_demux_if.slave         in_if,
    av_st_chan_demux_if.master        out0_if,
    av_st_chan_demux_if.master        out1_if,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output route_state_t              o_state
);

    // Flat payload layout: {dest, channel, data, empty, sop, eop, error}
    localparam int OFF_EOP   = 1;
    localparam int OFF_SOP   = 2;
    localparam int OFF_EMPTY = 3;
    localparam int OFF_DATA  = OFF_EMPTY + EMPTY_WIDTH;
    localparam int OFF_CHAN  = OFF_DATA + DATA_WIDTH;
    localparam int OFF_DEST  = OFF_CHAN + CHAN_WIDTH;
    localparam int PAY_W     = OFF_DEST + 1;

    route_state_t              r_state;
    logic                      r_dest;
    logic [DROP_CNT_WIDTH-1:0] r_drop_count;

    logic             w_not_full;
    logic             w_accept;
    logic             w_sel;
    logic             w_dest_tag;
    logic             w_push;
    logic             w_drop_evt;
    logic [PAY_W-1:0] w_wr_data;
    logic [PAY_W-1:0] w_head;
    logic             w_head_valid;
    logic             w_head_dest;
    logic             w_pop;

    assign in_if.ready = w_not_full;
    assign w_accept    = in_if.valid && w_not_full;
    assign w_sel       = (in_if.channel == CHAN_WIDTH'(PORT1_CHANNEL));
    assign w_dest_tag  = in_if.startofpacket ? w_sel : r_dest;

    // Stray mid-packet beats in IDLE and SOPs that truncate an open packet both count as drops.
    assign w_push     = w_accept && (in_if.startofpacket || (r_state == ST_IN_PKT));
    assign w_drop_evt = w_accept &&
                        (((r_state == ST_IDLE)   && !in_if.startofpacket) ||
                         ((r_state == ST_IN_PKT) &&  in_if.startofpacket));

    assign w_wr_data = {w_dest_tag, in_if.channel, in_if.data, in_if.empty,
                        in_if.startofpacket, in_if.endofpacket, in_if.error};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_dest  <= 1'b0;
        end else if (w_accept) begin
            if (in_if.startofpacket) begin
                r_dest  <= w_sel;
                r_state <= in_if.endofpacket ? ST_IDLE : ST_IN_PKT;
            end else if ((r_state == ST_IN_PKT) && in_if.endofpacket) begin
                r_state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_drop_evt && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    av_st_skid_fifo2 #(
        .WIDTH (PAY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_push),
        .i_wr_data  (w_wr_data),
        .o_not_full (w_not_full),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_head),
        .o_rd_valid (w_head_valid)
    );

    assign w_head_dest = w_head[OFF_DEST];
    assign w_pop       = w_head_valid && (w_head_dest ? out1_if.ready : out0_if.ready);

    assign out0_if.valid         = w_head_valid && !w_head_dest;
    assign out0_if.channel       = w_head[OFF_CHAN +: CHAN_WIDTH];
    assign out0_if.data          = w_head[OFF_DATA +: DATA_WIDTH];
    assign out0_if.empty         = w_head[OFF_EMPTY +: EMPTY_WIDTH];
    assign out0_if.startofpacket = w_head[OFF_SOP];
    assign out0_if.endofpacket   = w_head[OFF_EOP];
    assign out0_if.error         = w_head[0];

    assign out1_if.valid         = w_head_valid && w_head_dest;
    assign out1_if.channel       = w_head[OFF_CHAN +: CHAN_WIDTH];
    assign out1_if.data          = w_head[OFF_DATA +: DATA_WIDTH];
    assign out1_if.empty         = w_head[OFF_EMPTY +: EMPTY_WIDTH];
    assign out1_if.startofpacket = w_head[OFF_SOP];
    assign out1_if.endofpacket   = w_head[OFF_EOP];
    assign out1_if.error         = w_head[0];

    assign drop_count = r_drop_count;
    assign o_state    = r_state;

endmodule

// File: tb/tb_av_st_chan_demux.sv
// Directed self-checking bench for av_st_chan_demux; a second instance with
// a 2-bit drop counter exercises saturation.
module tb_av_st_chan_demux;
    import av_st_pkg::*;

    logic         clk;
    logic         reset;
    logic [15:0]  drop_count;
    logic [1:0]   sat_drop_count;
    route_state_t state;
    route_state_t sat_state;
    int           checks;
    int           errors;

    av_st_chan_demux_if #(.CHAN_WIDTH(1), .DATA_WIDTH(32), .EMPTY_WIDTH(2)) in_if   ();
    av_st_chan_demux_if #(.CHAN_WIDTH(1), .DATA_WIDTH(32), .EMPTY_WIDTH(2)) out0_if ();
    av_st_chan_demux_if #(.CHAN_WIDTH(1), .DATA_WIDTH(32), .EMPTY_WIDTH(2)) out1_if ();
    av_st_chan_demux_if #(.CHAN_WIDTH(1), .DATA_WIDTH(32), .EMPTY_WIDTH(2)) sin_if  ();
    av_st_chan_demux_if #(.CHAN_WIDTH(1), .DATA_WIDTH(32), .EMPTY_WIDTH(2)) sout0_if ();
    av_st_chan_demux_if #(.CHAN_WIDTH(1), .DATA_WIDTH(32), .EMPTY_WIDTH(2)) sout1_if ();

    av_st_chan_demux dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (in_if),
        .out0_if    (out0_if),
        .out1_if    (out1_if),
        .drop_count (drop_count),
        .o_state    (state)
    );

    av_st_chan_demux #(.DROP_CNT_WIDTH(2)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .in_if      (sin_if),
        .out0_if    (sout0_if),
        .out1_if    (sout1_if),
        .drop_count (sat_drop_count),
        .o_state    (sat_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic ch, input logic [31:0] d, input logic sop, input logic eop);
        in_if.channel       = ch;
        in_if.data          = d;
        in_if.empty         = d[1:0];
        in_if.error         = d[2];
        in_if.startofpacket = sop;
        in_if.endofpacket   = eop;
        in_if.valid         = 1'b1;
    endtask

    task automatic idle();
        in_if.valid         = 1'b0;
        in_if.startofpacket = 1'b0;
        in_if.endofpacket   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_if.ready); end
        checks++; if (out0_if.valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid got %0b exp 0", out0_if.valid); end
        checks++; if (out1_if.valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got %0b exp 0", out1_if.valid); end
        checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop got %0h exp 0", drop_count); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        reset = 1'b0;
        tick();
        checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b exp 1", in_if.ready); end
    endtask

    task automatic test_route_ch1();
        logic [31:0] exp_d;
        out0_if.ready = 1'b1;
        out1_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_d = 32'hA0 + 32'(i);
            set_beat(1'b1, exp_d, i == 0, i == 2);
            tick();
            checks++; if (out1_if.valid !== 1'b1) begin errors++; $display("FAIL route_out1_valid beat %0d got %0b exp 1", i, out1_if.valid); end
            checks++; if (out1_if.data !== exp_d) begin errors++; $display("FAIL route_out1_data beat %0d got %0h exp %0h", i, out1_if.data, exp_d); end
            checks++; if (out1_if.startofpacket !== (i == 0)) begin errors++; $display("FAIL route_sop beat %0d got %0b", i, out1_if.startofpacket); end
            checks++; if (out1_if.endofpacket !== (i == 2)) begin errors++; $display("FAIL route_eop beat %0d got %0b", i, out1_if.endofpacket); end
            checks++; if (out1_if.empty !== exp_d[1:0]) begin errors++; $display("FAIL route_empty beat %0d got %0h exp %0h", i, out1_if.empty, exp_d[1:0]); end
            checks++; if (out1_if.error !== exp_d[2]) begin errors++; $display("FAIL route_error beat %0d got %0b exp %0b", i, out1_if.error, exp_d[2]); end
            checks++; if (out0_if.valid !== 1'b0) begin errors++; $display("FAIL route_out0_quiet beat %0d got %0b exp 0", i, out0_if.valid); end
        end
        idle();
        tick();
        checks++; if (out1_if.valid !== 1'b0) begin errors++; $display("FAIL route_drained got %0b exp 0", out1_if.valid); end
    endtask

    task automatic test_latch();
        logic        chans [4];
        logic [31:0] exp_d;
        chans = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'hB0 + 32'(i);
            set_beat(chans[i], exp_d, i == 0, i == 3);
            tick();
            checks++; if (out0_if.valid !== 1'b1) begin errors++; $display("FAIL latch_out0_valid beat %0d got %0b exp 1", i, out0_if.valid); end
            checks++; if (out0_if.data !== exp_d) begin errors++; $display("FAIL latch_data beat %0d got %0h exp %0h", i, out0_if.data, exp_d); end
            checks++; if (out0_if.channel !== chans[i]) begin errors++; $display("FAIL latch_channel beat %0d got %0b exp %0b", i, out0_if.channel, chans[i]); end
            checks++; if (out1_if.valid !== 1'b0) begin errors++; $display("FAIL latch_out1_quiet beat %0d got %0b exp 0", i, out1_if.valid); end
        end
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        int   idx;
        logic rdy;
        idx = 0;
        out0_if.ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 5) set_beat(1'b0, 32'hC0 + 32'(idx), idx == 0, idx == 4);
            rdy = in_if.ready;
            tick();
            if (rdy) idx++;
        end
        checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", idx); end
        checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b exp 0", in_if.ready); end
        checks++; if (out0_if.data !== 32'hC0) begin errors++; $display("FAIL bp_head got %0h exp c0", out0_if.data); end
        out0_if.ready = 1'b1;
        tick();
        checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %0b exp 1", in_if.ready); end
        checks++; if (out0_if.data !== 32'hC1) begin errors++; $display("FAIL bp_second got %0h exp c1", out0_if.data); end
        idle();
        tick();
        checks++; if (out0_if.valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b exp 0", out0_if.valid); end
        // Close the still-open packet with a non-SOP EOP beat; it follows the latched port.
        set_beat(1'b1, 32'hC2, 1'b0, 1'b1);
        tick();
        checks++; if (out0_if.valid !== 1'b1 || out0_if.data !== 32'hC2) begin errors++; $display("FAIL bp_close got v%0b %0h exp v1 c2", out0_if.valid, out0_if.data); end
        idle();
        tick();
    endtask

    task automatic test_head_of_line();
        out0_if.ready = 1'b0;
        out1_if.ready = 1'b1;
        set_beat(1'b0, 32'hD0, 1'b1, 1'b1);
        tick();
        set_beat(1'b1, 32'hE0, 1'b1, 1'b1);
        tick();
        idle();
        checks++; if (out0_if.valid !== 1'b1 || out0_if.data !== 32'hD0) begin errors++; $display("FAIL hol_head got v%0b %0h exp v1 d0", out0_if.valid, out0_if.data); end
        checks++; if (out1_if.valid !== 1'b0) begin errors++; $display("FAIL hol_blocked got %0b exp 0", out1_if.valid); end
        tick();
        checks++; if (out1_if.valid !== 1'b0) begin errors++; $display("FAIL hol_still_blocked got %0b exp 0", out1_if.valid); end
        out0_if.ready = 1'b1;
        tick();
        checks++; if (out1_if.valid !== 1'b1 || out1_if.data !== 32'hE0) begin errors++; $display("FAIL hol_release got v%0b %0h exp v1 e0", out1_if.valid, out1_if.data); end
        checks++; if (out0_if.valid !== 1'b0) begin errors++; $display("FAIL hol_out0_after got %0b exp 0", out0_if.valid); end
        tick();
        checks++; if (out1_if.valid !== 1'b0) begin errors++; $display("FAIL hol_empty got %0b exp 0", out1_if.valid); end
    endtask

    task automatic test_framing();
        set_beat(1'b0, 32'hF0, 1'b0, 1'b0);
        tick();
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL frame_stray_drop got %0d exp 1", drop_count); end
        checks++; if (out0_if.valid !== 1'b0 || out1_if.valid !== 1'b0) begin errors++; $display("FAIL frame_stray_hidden got %0b%0b exp 00", out0_if.valid, out1_if.valid); end
        set_beat(1'b0, 32'hF1, 1'b1, 1'b0);
        tick();
        checks++; if (out0_if.valid !== 1'b1 || out0_if.data !== 32'hF1) begin errors++; $display("FAIL frame_sop1 got v%0b %0h exp v1 f1", out0_if.valid, out0_if.data); end
        set_beat(1'b1, 32'hF2, 1'b1, 1'b0);
        tick();
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL frame_trunc_drop got %0d exp 2", drop_count); end
        checks++; if (out1_if.valid !== 1'b1 || out1_if.data !== 32'hF2) begin errors++; $display("FAIL frame_reroute got v%0b %0h exp v1 f2", out1_if.valid, out1_if.data); end
        set_beat(1'b0, 32'hF3, 1'b0, 1'b1);
        tick();
        checks++; if (out1_if.valid !== 1'b1 || out1_if.data !== 32'hF3 || out1_if.endofpacket !== 1'b1) begin errors++; $display("FAIL frame_eop got v%0b %0h e%0b exp v1 f3 e1", out1_if.valid, out1_if.data, out1_if.endofpacket); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL frame_final_drop got %0d exp 2", drop_count); end
        idle();
        tick();
        checks++; if (out0_if.valid !== 1'b0 || out1_if.valid !== 1'b0) begin errors++; $display("FAIL frame_drained got %0b%0b exp 00", out0_if.valid, out1_if.valid); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt;
        sin_if.valid         = 1'b1;
        sin_if.startofpacket = 1'b0;
        sin_if.endofpacket   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++; if (sat_drop_count !== exp_cnt) begin errors++; $display("FAIL sat_drop step %0d got %0d exp %0d", i, sat_drop_count, exp_cnt); end
        end
        sin_if.valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_beat(1'b1, 32'h60, 1'b1, 1'b0);
        tick();
        set_beat(1'b1, 32'h61, 1'b0, 1'b0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        checks++; if (out0_if.valid !== 1'b0 || out1_if.valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b%0b exp 00", out0_if.valid, out1_if.valid); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_mid_drop got %0d exp 0", drop_count); end
        reset = 1'b0;
        tick();
        set_beat(1'b0, 32'h70, 1'b1, 1'b0);
        tick();
        checks++; if (out0_if.valid !== 1'b1 || out0_if.data !== 32'h70) begin errors++; $display("FAIL rst_mid_fresh got v%0b %0h exp v1 70", out0_if.valid, out0_if.data); end
        set_beat(1'b1, 32'h71, 1'b0, 1'b1);
        tick();
        checks++; if (out0_if.valid !== 1'b1 || out0_if.data !== 32'h71) begin errors++; $display("FAIL rst_mid_tail got v%0b %0h exp v1 71", out0_if.valid, out0_if.data); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_mid_nodrop got %0d exp 0", drop_count); end
        idle();
        tick();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        in_if.channel  = 1'b0;
        in_if.data     = '0;
        in_if.empty    = '0;
        in_if.error    = 1'b0;
        idle();
        out0_if.ready  = 1'b1;
        out1_if.ready  = 1'b1;
        sin_if.channel = 1'b0;
        sin_if.data    = '0;
        sin_if.empty   = '0;
        sin_if.error   = 1'b0;
        sin_if.startofpacket = 1'b0;
        sin_if.endofpacket   = 1'b0;
        sin_if.valid   = 1'b0;
        sout0_if.ready = 1'b1;
        sout1_if.ready = 1'b1;

        test_reset();
        test_route_ch1();
        test_latch();
        test_backpressure();
        test_head_of_line();
        test_framing();
        test_saturate();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/av_st_chan_demux.md
Name: av_st_chan_demux

Overview:
- Packet-aware 1-to-2 Avalon-ST demultiplexer; the return-direction counterpart of the fixed 2:1 stream mux.
- Routes whole packets from one input stream to out0 or out1. The destination is chosen from in_channel on the startofpacket beat and held until endofpacket.
- Has a 2-entry beat buffer, so in_ready is registered and has no combinational path from either out*_ready.
- Sits between a shared ingress stream and two per-port consumers, e.g. FC port pipelines.

Parameters:
- BITS_PER_SYMBOL, 8, bits per symbol.
- SYMBOLS_PER_BEAT, 4, symbols per beat.
- CHAN_WIDTH, 1, channel field width.
- PORT1_CHANNEL, 1, channel value routed to out1; every other value goes to out0.
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.
- DATA_WIDTH, BITS_PER_SYMBOL*SYMBOLS_PER_BEAT, derived.
- EMPTY_WIDTH, $clog2(SYMBOLS_PER_BEAT), derived.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_channel, in_data, in_empty, in_startofpacket, in_endofpacket, in_error, in_valid  in  CHAN_WIDTH/DATA_WIDTH/EMPTY_WIDTH/1/1/1/1  sink beat.
- in_ready  out  1  sink ready; readyLatency 0.
- out0_channel, out0_data, out0_empty, out0_startofpacket, out0_endofpacket, out0_error, out0_valid  out  same widths  source 0.
- out0_ready  in  1  source 0 ready.
- out1_* (same set as out0_*)  out  same widths  source 1.
- out1_ready  in  1  source 1 ready.
- drop_count  out  DROP_CNT_WIDTH  number of beats dropped for framing errors; saturating.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - All out*_valid = 0, in_ready = 0, drop_count = 0.
  - Buffer empty, in_pkt = 0, dest = 0.
  - in_ready goes to 1 on the first cycle after reset deasserts.
  - Data outputs are don't-care while their valid is low.
- Accept rule:
  - A beat is accepted when in_valid && in_ready.
  - in_ready = (count < 2), registered from next-state occupancy.
- Routing state (two states, IDLE and IN_PKT):
  - IDLE, accepted beat with SOP: dest_next = (in_channel == PORT1_CHANNEL). The beat is tagged dest_next. If EOP is also set, stay IDLE; otherwise go to IN_PKT.
  - IDLE, accepted beat without SOP: beat is dropped (not written), drop_count++.
  - IN_PKT, accepted beat without SOP: tagged with the latched dest. EOP moves to IDLE.
  - IN_PKT, accepted beat with SOP: the previous packet is truncated. drop_count++ once for the missing EOP. The new beat is processed as an IDLE SOP (re-route, re-latch).
  - in_channel on non-SOP beats is ignored for routing but is forwarded unchanged.
- Buffer:
  - 2-entry FIFO holding {beat, dest}. The head is presented only on out[dest]; the other output's valid is 0.
  - Head pops when out[dest]_valid && out[dest]_ready. The ready of the non-selected port is ignored.
  - Latency from accept to out*_valid is 1 cycle.
  - Push and pop in the same cycle keep count unchanged. Sustained throughput is 1 beat/clk when the destination ready is held high.
- Ordering: beats leave in arrival order. No reordering between ports; head-of-line blocking is accepted.
- Full / empty:
  - count == 2 → in_ready = 0 in the following cycle. in_ready stays 0 until a pop occurs.
  - count == 0 → both out*_valid = 0.
- drop_count: increments by 1 per event and saturates at all-ones; it does not wrap.
- Reset mid-packet: the buffer is flushed and the state returns to IDLE. Partially delivered packets are not terminated. Downstream must tolerate this.
- Field passthrough: channel, empty, error, SOP and EOP are passed through unmodified.

Decomposition:
- Package av_st_pkg: the beat struct {channel, data, empty, sop, eop, error}, sized by the parameters. Also holds the routing state enum (IDLE, IN_PKT).
- Sub-module av_st_skid_fifo2: the 2-entry registered FIFO with registered not-full output. It is generic in payload width (beat + dest bit).
- Top level: route FSM, drop counter, output steering.

Test Plan:
- Routing by channel: reset, then a 3-beat packet with channel=1 (data 0xA0,0xA1,0xA2), both readies high. out1 carries the 3 beats starting 1 cycle after the first accept, SOP on 0xA0 and EOP on 0xA2; out0_valid stays 0.
- Channel latched at SOP: a 4-beat packet with SOP channel=0 and channel=1 on beats 2–4. All 4 beats appear on out0, with channel fields forwarded as driven.
- Backpressure / full: out0_ready=0 while 5 beats are offered to port 0. Exactly 2 are accepted and in_ready drops to 0. Raising out0_ready drains them in order, and in_ready returns to 1 the cycle after the first pop.
- Head-of-line: packet A (1 beat, ch0), then packet B (1 beat, ch1), with out0_ready=0 and out1_ready=1. out1_valid stays 0 until A pops, and order is preserved.
- Framing errors: a beat without SOP in IDLE, then SOP, SOP, EOP. drop_count = 2 and the first beat never appears. Forcing drop_count to all-ones and injecting another error holds it at 0xFFFF.
- Reset mid-packet: assert reset after 2 beats of a 4-beat packet. The next cycle has both out*_valid=0 and drop_count=0, and a fresh packet then routes correctly.
